duplex_xfer_ctrl: RTL and testbench

Transaction controller that shares one full-duplex serial link between NUM_REQ requesters. It arbitrates round-robin, launches the link's transmit and receive FSMs together with a one-cycle start command, and waits for both completion pulses. It then returns the received word to the winning requester. A watchdog aborts hung transfers by pulsing a local link reset and returning a timeout response.

---
 rtl/duplex_xfer_ctrl.sv | 114 +++++++++++
 tb/tb_duplex_xfer_ctrl.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/duplex_xfer_ctrl.sv
// duplex_xfer_ctrl: round-robin arbiter that runs one full-duplex link transfer per grant
// and uses a watchdog to reset the link and return a timeout response when a transfer hangs.
module duplex_xfer_ctrl #(
    parameter int DATA_WIDTH_BASE = 5,
    parameter int NUM_REQ = 2,
    parameter int TIMEOUT = 255,
    parameter int ABORT_CYCLES = 4,
    localparam int W = 2 ** DATA_WIDTH_BASE
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_REQ-1:0]   req_valid,
    output logic [NUM_REQ-1:0]   req_ready,
    input  logic [NUM_REQ*W-1:0] req_wdata,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [2:0]           rsp_id,
    output logic [W-1:0]         rsp_rdata,
    output logic                 rsp_timeout,
    output logic [1:0]           tx_cmd,
    output logic [1:0]           rx_cmd,
    output logic [W-1:0]         tx_word,
    input  logic                 tx_done,
    input  logic                 rx_done,
    input  logic [W-1:0]         rx_word,
    output logic                 link_rst_n,
    output logic                 busy
);
    typedef enum logic [2:0] {IDLE, LAUNCH, WAIT, ABORT, RESP} state_t;
    state_t state, state_nxt;
    logic [2:0] ptr, win;
    logic [7:0] vld;
    logic [7:0] timer;
    logic [3:0] acnt;
    logic [W-1:0] wsel;
    logic found, tx_seen, rx_seen;
    assign vld = 8'(req_valid);
    // Search starts just after the last served requester and wraps around.
    always_comb begin
        win = '0;
        found = 1'b0;
        wsel = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            if (!found && vld[3'((int'(ptr) + k) % NUM_REQ)]) begin
                win = 3'((int'(ptr) + k) % NUM_REQ);
                found = 1'b1;
            end
        end
        for (int i = 0; i < NUM_REQ; i++)
            if (win == 3'(i)) wsel = req_wdata[i*W +: W];
    end
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = found ? LAUNCH : IDLE;
            LAUNCH:  state_nxt = WAIT;
            WAIT:    state_nxt = ((tx_seen | tx_done) && (rx_seen | rx_done)) ? RESP :
                                 (timer + 8'd1 == 8'(TIMEOUT)) ? ABORT : WAIT;
            ABORT:   state_nxt = (acnt == 4'(ABORT_CYCLES - 1)) ? RESP : ABORT;
            RESP:    state_nxt = rsp_ready ? IDLE : RESP;
            default: state_nxt = IDLE;
        endcase
        req_ready  = (state == IDLE) ? (NUM_REQ'(found) << win) : '0;
        tx_cmd     = (state == LAUNCH) ? 2'd1 : 2'd0;
        rx_cmd     = (state == LAUNCH) ? 2'd1 : 2'd0;
        rsp_valid  = (state == RESP);
        link_rst_n = (state != ABORT);
        busy       = (state != IDLE);
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            ptr         <= 3'(NUM_REQ - 1);
            rsp_id      <= '0;
            tx_word     <= '0;
            rsp_rdata   <= '0;
            rsp_timeout <= 1'b0;
            tx_seen     <= 1'b0;
            rx_seen     <= 1'b0;
            timer       <= '0;
            acnt        <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: if (found) begin
                    rsp_id  <= win;
                    tx_word <= wsel;
                end
                LAUNCH: begin
                    tx_seen <= 1'b0;
                    rx_seen <= 1'b0;
                    timer   <= '0;
                end
                WAIT: begin
                    tx_seen <= tx_seen | tx_done;
                    rx_seen <= rx_seen | rx_done;
                    timer   <= timer + 8'd1;
                    acnt    <= '0;
                    if (rx_done) rsp_rdata <= rx_word;
                    if (state_nxt == ABORT) begin
                        rsp_rdata   <= '0;
                        rsp_timeout <= 1'b1;
                    end
                end
                ABORT: acnt <= acnt + 4'd1;
                RESP: if (rsp_ready) begin
                    ptr         <= rsp_id;
                    rsp_timeout <= 1'b0;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_duplex_xfer_ctrl.sv
// tb_duplex_xfer_ctrl: directed bench for duplex_xfer_ctrl covering arbitration, completion,
// watchdog abort, response backpressure and asynchronous reset during a transfer.
module tb_duplex_xfer_ctrl;
    localparam logic [31:0] W0 = 32'hA5A5_0F0F;
    localparam logic [31:0] W1 = 32'h5A5A_F0F0;
    logic clk = 1'b0;
    logic rst = 1'b0;
    logic [1:0] req_valid = '0;
    logic [1:0] req_ready;
    logic [63:0] req_wdata = {W1, W0};
    logic rsp_valid;
    logic rsp_ready = 1'b0;
    logic [2:0] rsp_id;
    logic [31:0] rsp_rdata;
    logic rsp_timeout;
    logic [1:0] tx_cmd, rx_cmd;
    logic [31:0] tx_word;
    logic tx_done = 1'b0;
    logic rx_done = 1'b0;
    logic [31:0] rx_word = '0;
    logic link_rst_n, busy;
    int total = 0;
    int bad = 0;

    duplex_xfer_ctrl dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_id(rsp_id), .rsp_rdata(rsp_rdata), .rsp_timeout(rsp_timeout),
        .tx_cmd(tx_cmd), .rx_cmd(rx_cmd), .tx_word(tx_word), .tx_done(tx_done),
        .rx_done(rx_done), .rx_word(rx_word), .link_rst_n(link_rst_n), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One transfer where both done pulses land in the first WAIT cycle.
    task automatic xfer(input logic [1:0] vld, input logic [2:0] id, input logic [31:0] rw);
        logic [1:0] oh;
        oh = 2'b01 << id;
        req_valid = vld;
        #1;
        chk("grant", 64'(req_ready), 64'(oh));
        step();
        chk("launch_tx_cmd", 64'(tx_cmd), 64'd1);
        chk("launch_rx_cmd", 64'(rx_cmd), 64'd1);
        chk("tx_word", 64'(tx_word), 64'(id == 3'd0 ? W0 : W1));
        step();
        chk("wait_tx_cmd", 64'(tx_cmd), 64'd0);
        tx_done = 1'b1;
        rx_done = 1'b1;
        rx_word = rw;
        step();
        tx_done = 1'b0;
        rx_done = 1'b0;
        rx_word = '0;
        chk("rsp_valid", 64'(rsp_valid), 64'd1);
        chk("rsp_id", 64'(rsp_id), 64'(id));
        chk("rsp_rdata", 64'(rsp_rdata), 64'(rw));
        chk("rsp_timeout", 64'(rsp_timeout), 64'd0);
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        #1;
        chk("idle_busy", 64'(busy), 64'd0);
    endtask

    initial begin
        #2;
        chk("rst_req_ready", 64'(req_ready), 64'd0);
        chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rst_rsp_id", 64'(rsp_id), 64'd0);
        chk("rst_rsp_rdata", 64'(rsp_rdata), 64'd0);
        chk("rst_rsp_timeout", 64'(rsp_timeout), 64'd0);
        chk("rst_tx_cmd", 64'(tx_cmd), 64'd0);
        chk("rst_rx_cmd", 64'(rx_cmd), 64'd0);
        chk("rst_tx_word", 64'(tx_word), 64'd0);
        chk("rst_link", 64'(link_rst_n), 64'd1);
        chk("rst_busy", 64'(busy), 64'd0);
        step();
        step();
        rst = 1'b1;
        step();

        // single request, rx completes 4 cycles after tx
        req_valid = 2'b01;
        #1;
        chk("s_grant", 64'(req_ready), 64'd1);
        step();
        req_valid = 2'b00;
        chk("s_tx_cmd", 64'(tx_cmd), 64'd1);
        chk("s_rx_cmd", 64'(rx_cmd), 64'd1);
        chk("s_tx_word", 64'(tx_word), 64'(W0));
        chk("s_ready_launch", 64'(req_ready), 64'd0);
        step();
        chk("s_tx_cmd_wait", 64'(tx_cmd), 64'd0);
        chk("s_rx_cmd_wait", 64'(rx_cmd), 64'd0);
        tx_done = 1'b1;
        step();
        tx_done = 1'b0;
        step();
        step();
        step();
        rx_done = 1'b1;
        rx_word = 32'h1234_5678;
        chk("s_no_rsp_yet", 64'(rsp_valid), 64'd0);
        step();
        rx_done = 1'b0;
        rx_word = '0;
        chk("s_rsp_valid", 64'(rsp_valid), 64'd1);
        chk("s_rsp_id", 64'(rsp_id), 64'd0);
        chk("s_rsp_rdata", 64'(rsp_rdata), 64'h1234_5678);
        chk("s_rsp_timeout", 64'(rsp_timeout), 64'd0);
        chk("s_tx_word_held", 64'(tx_word), 64'(W0));
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        chk("s_idle", 64'(rsp_valid), 64'd0);

        // reset pulse restores pointer so contention starts at requester 0
        rst = 1'b0;
        #1;
        chk("p_tx_word", 64'(tx_word), 64'd0);
        step();
        rst = 1'b1;
        step();
        xfer(2'b11, 3'd0, 32'h0000_0001);
        xfer(2'b11, 3'd1, 32'h8000_0002);
        xfer(2'b11, 3'd0, 32'hFFFF_FFFF);

        // watchdog: only tx_done arrives
        req_valid = 2'b01;
        #1;
        chk("t_grant", 64'(req_ready), 64'd1);
        step();
        req_valid = 2'b00;
        step();
        tx_done = 1'b1;
        step();
        tx_done = 1'b0;
        repeat (253) step();
        chk("t_wait255_link", 64'(link_rst_n), 64'd1);
        chk("t_wait255_busy", 64'(busy), 64'd1);
        chk("t_wait255_rsp", 64'(rsp_valid), 64'd0);
        step();
        chk("t_abort1_link", 64'(link_rst_n), 64'd0);
        chk("t_abort_timeout", 64'(rsp_timeout), 64'd1);
        chk("t_abort_rdata", 64'(rsp_rdata), 64'd0);
        step();
        chk("t_abort2_link", 64'(link_rst_n), 64'd0);
        rx_done = 1'b1;
        tx_done = 1'b1;
        rx_word = 32'hDEAD_BEEF;
        step();
        rx_done = 1'b0;
        tx_done = 1'b0;
        rx_word = '0;
        chk("t_abort3_link", 64'(link_rst_n), 64'd0);
        step();
        chk("t_abort4_link", 64'(link_rst_n), 64'd0);
        step();
        chk("t_resp_link", 64'(link_rst_n), 64'd1);
        chk("t_resp_valid", 64'(rsp_valid), 64'd1);
        chk("t_resp_timeout", 64'(rsp_timeout), 64'd1);
        chk("t_resp_rdata", 64'(rsp_rdata), 64'd0);
        chk("t_resp_id", 64'(rsp_id), 64'd0);

        // backpressure with requester 1 pending
        req_valid = 2'b10;
        for (int i = 0; i < 10; i++) begin
            #1;
            chk("b_valid", 64'(rsp_valid), 64'd1);
            chk("b_timeout", 64'(rsp_timeout), 64'd1);
            chk("b_rdata", 64'(rsp_rdata), 64'd0);
            chk("b_id", 64'(rsp_id), 64'd0);
            chk("b_ready", 64'(req_ready), 64'd0);
            step();
        end
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        #1;
        chk("b_timeout_clr", 64'(rsp_timeout), 64'd0);
        chk("b_grant1", 64'(req_ready), 64'd2);
        xfer(2'b10, 3'd1, 32'hCAFE_0001);
        xfer(2'b01, 3'd0, 32'h0BAD_F00D);

        // async reset in the middle of WAIT
        req_valid = 2'b10;
        #1;
        chk("r_grant", 64'(req_ready), 64'd2);
        step();
        req_valid = 2'b00;
        step();
        tx_done = 1'b1;
        step();
        tx_done = 1'b0;
        chk("r_busy_wait", 64'(busy), 64'd1);
        rst = 1'b0;
        #1;
        chk("r_busy", 64'(busy), 64'd0);
        chk("r_tx_word", 64'(tx_word), 64'd0);
        chk("r_rsp_id", 64'(rsp_id), 64'd0);
        chk("r_rsp_rdata", 64'(rsp_rdata), 64'd0);
        chk("r_link", 64'(link_rst_n), 64'd1);
        chk("r_rsp_valid", 64'(rsp_valid), 64'd0);
        step();
        step();
        rst = 1'b1;
        step();
        chk("r_no_rsp", 64'(rsp_valid), 64'd0);
        xfer(2'b11, 3'd0, 32'h600D_CAFE);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
